// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for branch resolution: funct3 encodings, FSM state codes,
// and the 2-bit saturating predictor counter helpers.
package branch_ctrl_pkg;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_STALL    = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    // Weakly not-taken
    localparam logic [1:0] CTR_RESET = 2'b01;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/branch_ctrl_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port and one registered update port.
module branch_bht
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] cnt_q [ENTRIES];
    logic [1:0] cnt_d [ENTRIES];

    always_comb begin
        cnt_d = cnt_q;
        if (upd_en) begin
            cnt_d[upd_idx] = ctr_next(cnt_q[upd_idx], upd_taken);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CTR_RESET;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Reads the registered array, so a same-cycle update is not visible yet
    assign rd_taken = cnt_q[rd_idx][1];

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch resolution: stall on operand hazard, registered one-cycle
// redirect/flush, saturating statistics. Define BRANCH_PRED_EN to add the BHT.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned BHT_ENTRIES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic [2:0]       id_funct3,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic             opnd_hazard,
    input  logic             id_pred_taken,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    output logic             stall,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_ifid,
    output logic             br_illegal,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] br_taken_count
);

    logic [1:0]       state_q, state_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             br_illegal_q, br_illegal_d;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] br_taken_count_q, br_taken_count_d;

    logic             cond_taken;
    logic             cond_illegal;
    logic             need_redirect;
    logic             resolve;
    logic             stall_c;
    logic [XLEN-1:0]  target;

    always_comb begin
        cond_taken   = 1'b0;
        cond_illegal = 1'b0;
        case (id_funct3)
            F3_BEQ:  cond_taken = (id_rs1_data == id_rs2_data);
            F3_BNE:  cond_taken = (id_rs1_data != id_rs2_data);
            F3_BLT:  cond_taken = ($signed(id_rs1_data) <  $signed(id_rs2_data));
            F3_BGE:  cond_taken = ($signed(id_rs1_data) >= $signed(id_rs2_data));
            default: cond_illegal = 1'b1;
        endcase
    end

    assign target = cond_taken ? (id_pc + id_imm) : (id_pc + XLEN'(4));

`ifdef BRANCH_PRED_EN
    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    assign need_redirect = (cond_taken != id_pred_taken);

    branch_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (if_pc[IDX_W+1:2]),
        .rd_taken  (if_pred_taken),
        .upd_en    (resolve),
        .upd_idx   (id_pc[IDX_W+1:2]),
        .upd_taken (cond_taken)
    );

    logic unused_ok;
    assign unused_ok = ^{if_pc, id_pred_taken};
`else
    // Static not-taken: every taken branch is a misfetch
    assign need_redirect = cond_taken;
    assign if_pred_taken = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{if_pc, id_pred_taken, BHT_ENTRIES[0]};
`endif

    always_comb begin
        state_d = state_q;
        resolve = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_STALL: begin
                if (id_valid && id_is_branch) begin
                    if (opnd_hazard) begin
                        stall_c = 1'b1;
                        state_d = ST_STALL;
                    end else begin
                        resolve = 1'b1;
                        state_d = need_redirect ? ST_REDIRECT : ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // The ID instruction is being flushed, so its inputs are ignored
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        redirect_pc_d    = redirect_pc_q;
        br_illegal_d     = resolve & cond_illegal;
        br_count_d       = br_count_q;
        br_taken_count_d = br_taken_count_q;
        if (resolve) begin
            if (need_redirect) begin
                redirect_pc_d = target;
            end
            if (br_count_q != '1) begin
                br_count_d = br_count_q + CNT_W'(1);
            end
            if (cond_taken && (br_taken_count_q != '1)) begin
                br_taken_count_d = br_taken_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            redirect_pc_q    <= '0;
            br_illegal_q     <= 1'b0;
            br_count_q       <= '0;
            br_taken_count_q <= '0;
        end else begin
            state_q          <= state_d;
            redirect_pc_q    <= redirect_pc_d;
            br_illegal_q     <= br_illegal_d;
            br_count_q       <= br_count_d;
            br_taken_count_q <= br_taken_count_d;
        end
    end

    // Stall is combinational from ID inputs, so mask it while reset is held
    assign stall          = stall_c & ~rst;
    assign redirect_valid = (state_q == ST_REDIRECT);
    assign flush_ifid     = (state_q == ST_REDIRECT);
    assign redirect_pc    = redirect_pc_q;
    assign br_illegal     = br_illegal_q;
    assign br_count       = br_count_q;
    assign br_taken_count = br_taken_count_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl; predictor checks are built
// only when BRANCH_PRED_EN is defined.
module tb_branch_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_is_branch;
    logic [2:0]  id_funct3;
    logic [31:0] id_pc;
    logic [31:0] id_imm;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic        opnd_hazard;
    logic        id_pred_taken;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_ifid;
    logic        br_illegal;
    logic [3:0]  br_count;
    logic [3:0]  br_taken_count;

    int vectors     = 0;
    int miscompares = 0;

    branch_ctrl #(
        .XLEN        (32),
        .CNT_W       (4),
        .BHT_ENTRIES (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_is_branch   (id_is_branch),
        .id_funct3      (id_funct3),
        .id_pc          (id_pc),
        .id_imm         (id_imm),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .opnd_hazard    (opnd_hazard),
        .id_pred_taken  (id_pred_taken),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_ifid     (flush_ifid),
        .br_illegal     (br_illegal),
        .br_count       (br_count),
        .br_taken_count (br_taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                            input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic haz, input logic pred);
        id_valid      = 1'b1;
        id_is_branch  = 1'b1;
        id_funct3     = f3;
        id_pc         = pc;
        id_imm        = imm;
        id_rs1_data   = rs1;
        id_rs2_data   = rs2;
        opnd_hazard   = haz;
        id_pred_taken = pred;
        #1;
    endtask

    task automatic drive_idle();
        id_valid      = 1'b0;
        id_is_branch  = 1'b0;
        opnd_hazard   = 1'b0;
        id_pred_taken = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        id_funct3 = 3'b000; id_pc = '0; id_imm = '0;
        id_rs1_data = '0; id_rs2_data = '0; if_pc = '0;
        drive_idle();
        tick(); tick();

        // Reset state
        check("rst_stall",    32'(stall),          32'd0);
        check("rst_redir",    32'(redirect_valid), 32'd0);
        check("rst_redir_pc", redirect_pc,         32'd0);
        check("rst_flush",    32'(flush_ifid),     32'd0);
        check("rst_illegal",  32'(br_illegal),     32'd0);
        check("rst_count",    32'(br_count),       32'd0);
        check("rst_taken",    32'(br_taken_count), 32'd0);
        rst = 1'b0;
        tick();

        // 1: beq taken, pc 0x100 + 0x20
        drive_br(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 1'b0);
        check("t1_no_stall", 32'(stall), 32'd0);
        tick();
        // A hazarded branch seen during REDIRECT is being flushed: no stall, no count
        drive_br(3'b000, 32'h104, 32'h8, 32'd1, 32'd1, 1'b1, 1'b0);
        check("t1_redir",    32'(redirect_valid), 32'd1);
        check("t1_redir_pc", redirect_pc,         32'h120);
        check("t1_flush",    32'(flush_ifid),     32'd1);
        check("t1_cnt",      32'(br_count),       32'd1);
        check("t1_taken",    32'(br_taken_count), 32'd1);
        check("t1_ign_stall", 32'(stall),         32'd0);
        drive_idle();
        tick();
        check("t1_redir_off", 32'(redirect_valid), 32'd0);
        check("t1_flush_off", 32'(flush_ifid),     32'd0);
        check("t1_ign_cnt",   32'(br_count),       32'd1);

        // 2: blt -1 < 1 taken, then bge same operands not taken
        drive_br(3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        tick();
        drive_idle();
        check("t2_blt_redir", 32'(redirect_valid), 32'd1);
        check("t2_blt_pc",    redirect_pc,         32'h240);
        check("t2_blt_taken", 32'(br_taken_count), 32'd2);
        tick();
        drive_br(3'b101, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        tick();
        drive_idle();
        check("t2_bge_redir", 32'(redirect_valid), 32'd0);
        check("t2_bge_cnt",   32'(br_count),       32'd3);
        check("t2_bge_taken", 32'(br_taken_count), 32'd2);

        // 3: bne with hazard for 2 cycles, backward target 0x400-16
        drive_br(3'b001, 32'h400, 32'hFFFF_FFF0, 32'd1, 32'd2, 1'b1, 1'b0);
        check("t3_stall_c1", 32'(stall), 32'd1);
        tick();
        check("t3_stall_c2", 32'(stall), 32'd1);
        tick();
        opnd_hazard = 1'b0;
        #1;
        check("t3_stall_c3", 32'(stall),          32'd0);
        check("t3_cnt_pre",  32'(br_count),       32'd3);
        tick();
        drive_idle();
        check("t3_redir",    32'(redirect_valid), 32'd1);
        check("t3_redir_pc", redirect_pc,         32'h3F0);
        check("t3_cnt",      32'(br_count),       32'd4);
        check("t3_taken",    32'(br_taken_count), 32'd3);
        tick();

        // 4: unsupported funct3 010
        drive_br(3'b010, 32'h500, 32'h40, 32'd7, 32'd7, 1'b0, 1'b0);
        tick();
        drive_idle();
        check("t4_illegal",  32'(br_illegal),     32'd1);
        check("t4_redir",    32'(redirect_valid), 32'd0);
        check("t4_cnt",      32'(br_count),       32'd5);
        check("t4_taken",    32'(br_taken_count), 32'd3);
        tick();
        check("t4_illegal_off", 32'(br_illegal),  32'd0);

        // Target wrap: 0xFFFFFFF0 + 0x20
        drive_br(3'b000, 32'hFFFF_FFF0, 32'h20, 32'd9, 32'd9, 1'b0, 1'b0);
        tick();
        drive_idle();
        check("wrap_redir_pc", redirect_pc,          32'h10);
        check("wrap_taken",    32'(br_taken_count),  32'd4);
        tick();

        // Counter saturation at 4'hF: 15 back-to-back not-taken bge from count 6
        for (int i = 0; i < 15; i++) begin
            drive_br(3'b101, 32'h700 + 32'(i * 4), 32'h40, 32'd0, 32'd1, 1'b0, 1'b0);
            tick();
        end
        drive_idle();
        check("sat_cnt",   32'(br_count),       32'd15);
        check("sat_taken", 32'(br_taken_count), 32'd4);
        check("sat_redir", 32'(redirect_valid), 32'd0);

        // 5: reset while stalled
        drive_br(3'b001, 32'h800, 32'h40, 32'd1, 32'd2, 1'b1, 1'b0);
        tick();
        check("t5_stall_pre", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_stall",  32'(stall),          32'd0);
        check("t5_redir",  32'(redirect_valid), 32'd0);
        check("t5_cnt",    32'(br_count),       32'd0);
        check("t5_taken",  32'(br_taken_count), 32'd0);
        drive_idle();
        tick();
        rst = 1'b0;
        tick();

`ifdef BRANCH_PRED_EN
        // 6: predictor training and mispredict recovery with PC wrap
        if_pc = 32'h600;
        drive_br(3'b000, 32'h600, 32'h80, 32'd5, 32'd5, 1'b0, 1'b0);
        check("t6_pred_init", 32'(if_pred_taken), 32'd0);
        tick();
        drive_idle();
        check("t6_redir1",    32'(redirect_valid), 32'd1);
        check("t6_redir1_pc", redirect_pc,         32'h680);
        check("t6_pred_1x",   32'(if_pred_taken),  32'd1);
        tick();
        drive_br(3'b000, 32'h600, 32'h80, 32'd5, 32'd5, 1'b0, 1'b1);
        tick();
        drive_idle();
        check("t6_no_redir",  32'(redirect_valid), 32'd0);
        check("t6_pred_2x",   32'(if_pred_taken),  32'd1);
        drive_br(3'b001, 32'hFFFF_FFFC, 32'h80, 32'd5, 32'd5, 1'b0, 1'b1);
        tick();
        drive_idle();
        check("t6_mis_redir", 32'(redirect_valid), 32'd1);
        check("t6_mis_pc",    redirect_pc,         32'h0);
        tick();
`else
        if_pc = 32'h600;
        #1;
        check("nopred_tied0", 32'(if_pred_taken), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
